// File: rtl/add_serial_pkg.sv
// Shared definitions for the serial adder and its issue stage: FSM state
// encoding and the default datapath width.
package add_serial_pkg;

    localparam int ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/add_issue_fifo.sv
// Operand FIFO for the serial-adder issue stage; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module add_issue_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                       (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[PW-1:0]];

    // Pointer update; both may move in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/add_serial_issuer.sv
// Issue/capture stage around the serial adder: queues operand pairs, issues one
// adder op at a time, captures the result after LATENCY cycles.
// Optional statistics ports are enabled with ADD_ISSUE_STATS_EN.
module add_serial_issuer
    import add_serial_pkg::*;
#(
    parameter int WIDTH   = ADD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
`ifdef ADD_ISSUE_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic             drop_err
`endif
);

    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [7:0]           cnt_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [2*WIDTH-1:0]   fifo_head_s;
    logic                 push_s;
    logic                 pop_s;

    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;
    assign pop_s    = (state_r == S_IDLE) && !fifo_empty_s;

    add_issue_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_a, in_b}),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) state_nxt_s = S_ISSUE;
                else               state_nxt_s = S_IDLE;
            end
            S_ISSUE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (cnt_r == 8'd0) state_nxt_s = S_HOLD;
                else               state_nxt_s = S_WAIT;
            end
            S_HOLD: begin
                if (res_ready) state_nxt_s = S_IDLE;
                else           state_nxt_s = S_HOLD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Registered outputs: en/busy come from the next state so they line up
    // with the state register and stay glitch-free toward the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_en    <= 1'b0;
            busy      <= 1'b0;
            cnt_r     <= 8'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            add_en <= (state_nxt_s == S_ISSUE);
            busy   <= (state_nxt_s != S_IDLE);
            if (pop_s) begin
                {add_a, add_b} <= fifo_head_s;
            end
            if (state_r == S_ISSUE) begin
                cnt_r <= WAIT_LOAD;
            end else if ((state_r == S_WAIT) && (cnt_r != 8'd0)) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if ((state_r == S_WAIT) && (cnt_r == 8'd0)) begin
                res_valid <= 1'b1;
                res_data  <= add_out;
            end else if ((state_r == S_HOLD) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ADD_ISSUE_STATS_EN
    // Result-handshake counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
            drop_err <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                op_count <= op_count + 16'd1;
            end
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_serial_issuer.sv
// Self-checking bench for add_serial_issuer: time-based reference model of
// queue occupancy and operation timing, plus a simple adder model on add_out.
module tb_add_serial_issuer;
    import add_serial_pkg::*;

    localparam int W = 8;
    localparam int D = 4;
    localparam int L = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = 8'h00;
    logic [W-1:0] in_b = 8'h00;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_en;
    logic [W-1:0] add_out = 8'h00;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         busy;
`ifdef ADD_ISSUE_STATS_EN
    logic [15:0]  op_count;
    logic         drop_err;
`endif

    always #5 clk = ~clk;

    add_serial_issuer #(.WIDTH(W), .DEPTH(D), .LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
`ifdef ADD_ISSUE_STATS_EN
        ,
        .op_count  (op_count),
        .drop_err  (drop_err)
`endif
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    pair_t       q[$];
    pair_t       cur;
    bit          active = 1'b0;
    int          pop_c = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          pin_t = -100;
    bit          pin_on = 1'b0;
    int          en_c = 0;
    bit          adder_has = 1'b0;
    logic [7:0]  adder_sum = 8'h00;
    logic [15:0] m_cnt = 16'd0;
    bit          m_drop = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: check outputs against the model, then advance the model.
    always @(negedge clk) begin
        bit         e_en;
        bit         e_rv;
        bit         e_busy;
        bit         e_ir;
        logic [7:0] e_sum;
        if (rst) begin
            chk("rst_in_ready", 16'(in_ready), 16'd1);
            chk("rst_add_a", 16'(add_a), 16'd0);
            chk("rst_add_b", 16'(add_b), 16'd0);
            chk("rst_add_en", 16'(add_en), 16'd0);
            chk("rst_res_valid", 16'(res_valid), 16'd0);
            chk("rst_res_data", 16'(res_data), 16'd0);
            chk("rst_busy", 16'(busy), 16'd0);
`ifdef ADD_ISSUE_STATS_EN
            chk("rst_op_count", op_count, 16'd0);
            chk("rst_drop_err", 16'(drop_err), 16'd0);
`endif
            q.delete();
            active    = 1'b0;
            adder_has = 1'b0;
            m_cnt     = 16'd0;
            m_drop    = 1'b0;
            add_out   = 8'($urandom);
        end else begin
            e_ir   = (q.size() < D);
            e_en   = active && (cyc == pop_c + 1);
            e_rv   = active && (cyc >= pop_c + 2 + L);
            e_busy = active && (cyc > pop_c);
            e_sum  = cur.a + cur.b;
            chk("in_ready", 16'(in_ready), 16'(e_ir));
            chk("add_en", 16'(add_en), 16'(e_en));
            chk("res_valid", 16'(res_valid), 16'(e_rv));
            chk("busy", 16'(busy), 16'(e_busy));
            if (e_busy) begin
                chk("add_a_hold", 16'(add_a), 16'(cur.a));
                chk("add_b_hold", 16'(add_b), 16'(cur.b));
            end
            if (e_rv) begin
                chk("res_data", 16'(res_data), 16'(e_sum));
            end
`ifdef ADD_ISSUE_STATS_EN
            chk("op_count", op_count, m_cnt);
            chk("drop_err", 16'(drop_err), 16'(m_drop));
`endif
            // Hand-computed timing of the directed single operation.
            if (pin_on && (cyc == pin_t + 1)) begin
                chk("pin_no_early_en", 16'(add_en), 16'd0);
            end
            if (pin_on && (cyc == pin_t + 2)) begin
                chk("pin_en", 16'(add_en), 16'd1);
                chk("pin_add_a", 16'(add_a), 16'h0012);
                chk("pin_add_b", 16'(add_b), 16'h0034);
                chk("pin_model_en", 16'(e_en), 16'd1);
            end
            if (pin_on && (cyc == pin_t + 14)) begin
                chk("pin_no_early_rv", 16'(res_valid), 16'd0);
            end
            if (pin_on && (cyc == pin_t + 15)) begin
                chk("pin_rv", 16'(res_valid), 16'd1);
                chk("pin_res_data", 16'(res_data), 16'h0046);
                chk("pin_model_rv", 16'(e_rv), 16'd1);
            end
            // Advance the model by one clock edge.
            if (e_rv && res_ready) begin
                active = 1'b0;
                m_cnt  = m_cnt + 16'd1;
            end else if (!active && (q.size() > 0)) begin
                cur    = q.pop_front();
                active = 1'b1;
                pop_c  = cyc;
            end
            if (in_valid && e_ir) begin
                q.push_back({in_a, in_b});
            end
            if (in_valid && !e_ir) begin
                m_drop = 1'b1;
            end
            // Adder: result settles L cycles after the enable, noise before that.
            if (add_en) begin
                adder_sum = add_a + add_b;
                en_c      = cyc;
                adder_has = 1'b1;
            end
            if (adder_has && (cyc - en_c >= L)) begin
                add_out = adder_sum;
            end else begin
                add_out = 8'($urandom);
            end
        end
        cyc = cyc + 1;
    end

    task automatic push_one(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single directed operation.
        res_ready = 1'b1;
        pin_t     = cyc;
        pin_on    = 1'b1;
        push_one(8'h12, 8'h34);
        repeat (20) @(posedge clk);
        #1;
        pin_on = 1'b0;

        // Two consecutive pushes while idle: second push meets the first pop.
        in_valid = 1'b1;
        in_a = 8'($urandom); in_b = 8'($urandom);
        @(posedge clk); #1;
        in_a = 8'($urandom); in_b = 8'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Fill past full under backpressure, then drain.
        res_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_a = 8'($urandom); in_b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (90) @(posedge clk);
        #1;

        // Reset in the middle of the wait window.
        push_one(8'hA5, 8'h5A);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // Randomized traffic with varied backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            res_ready = ($urandom_range(0, 4) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
